// File: rtl/const_seq_gen.sv
// -----------------------------------------------------------------------------
// const_seq_gen
//
// Registered value generator. Each rising edge the value O can be reset to a
// constant, loaded from D, stepped up or down by a constant STEP (wrapping or
// saturating), rotated left by one bit, or held. A sticky lock freezes the
// value until the next reset.
//
// Parameters
//   WIDTH  width of O and D (1..32)
//   INIT   value O takes at reset, truncated to WIDTH bits
//   STEP   add/subtract amount, truncated to WIDTH bits (1..2^WIDTH-1)
//   SAT    0 = wrap-around arithmetic, 1 = saturating arithmetic
//
// Ports
//   CLK     in   1      sole clock, rising edge
//   RST_N   in   1      synchronous active-low reset
//   EN      in   1      step enable (MODE applied only when EN=1)
//   MODE    in   2      00 hold, 01 add STEP, 10 subtract STEP, 11 rotate left
//   LD      in   1      load request, captures D
//   D       in   WIDTH  load data
//   LOCK    in   1      lock request, sticky until reset
//   O       out  WIDTH  current registered value
//   WRAP    out  1      one-cycle pulse after an add/sub that left the range
//   LD_ACK  out  1      one-cycle pulse after an accepted load
//   LOCKED  out  1      high while the lock is active
//
// Priority per edge (highest first): reset, locked, load, step, hold.
// A LOCK request on an unlocked edge still lets that edge's load/step apply;
// the freeze starts with the following edge.
// -----------------------------------------------------------------------------
module const_seq_gen #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned INIT  = 3,
    parameter int unsigned STEP  = 1,
    parameter bit          SAT   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             LOCK,
    output logic [WIDTH-1:0] O,
    output logic             WRAP,
    output logic             LD_ACK,
    output logic             LOCKED
);

    // MODE encodings
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_ROT  = 2'b11;

    // Parameters reduced to the working width once, so every datapath
    // operand below is exactly WIDTH bits.
    localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W  = {WIDTH{1'b0}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] o_reg,      o_next;
    logic             wrap_reg,   wrap_next;
    logic             ld_ack_reg, ld_ack_next;
    logic             locked_reg, locked_next;

    // -------------------------------------------------------------------------
    // Datapath candidates
    // -------------------------------------------------------------------------
    // Add and subtract are done one bit wider than the value so the top bit
    // is the carry (add) or borrow (sub); that bit is exactly "the true result
    // left 0..2^WIDTH-1" and feeds both WRAP and the saturation select.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_carry;
    logic             sub_borrow;
    logic [WIDTH-1:0] add_val;
    logic [WIDTH-1:0] sub_val;
    logic [WIDTH-1:0] rot_val;

    assign sum_ext    = {1'b0, o_reg} + {1'b0, STEP_W};
    assign diff_ext   = {1'b0, o_reg} - {1'b0, STEP_W};
    assign add_carry  = sum_ext[WIDTH];
    assign sub_borrow = diff_ext[WIDTH];

    // Saturation only changes the value on an out-of-range step; WRAP still
    // pulses, including when the value was already pinned at the bound.
    generate
        if (SAT) begin : g_sat
            assign add_val = add_carry  ? MAX_W : sum_ext[WIDTH-1:0];
            assign sub_val = sub_borrow ? MIN_W : diff_ext[WIDTH-1:0];
        end else begin : g_wrap
            assign add_val = sum_ext[WIDTH-1:0];
            assign sub_val = diff_ext[WIDTH-1:0];
        end
    endgenerate

    // Rotate left by one: bit gi takes bit gi-1, bit 0 takes the MSB. With
    // WIDTH=1 the index collapses to bit 0 onto itself, so the value holds.
    generate
        for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_rot
            assign rot_val[gi] = o_reg[(gi + int'(WIDTH) - 1) % int'(WIDTH)];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Pulses default low; value and lock default to holding.
        o_next      = o_reg;
        wrap_next   = 1'b0;
        ld_ack_next = 1'b0;
        locked_next = locked_reg;

        if (!locked_reg) begin
            // The lock request is taken now but only freezes later edges.
            if (LOCK) begin
                locked_next = 1'b1;
            end

            if (LD) begin
                o_next      = D;
                ld_ack_next = 1'b1;
            end else if (EN) begin
                unique case (MODE)
                    MODE_ADD: begin
                        o_next    = add_val;
                        wrap_next = add_carry;
                    end
                    MODE_SUB: begin
                        o_next    = sub_val;
                        wrap_next = sub_borrow;
                    end
                    MODE_ROT: begin
                        o_next = rot_val;
                    end
                    MODE_HOLD: begin
                        o_next = o_reg;
                    end
                    default: begin
                        o_next = o_reg;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register. Reset wins over everything, including an active lock,
    // and clears any pulse that would otherwise have been emitted.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_reg      <= INIT_W;
            wrap_reg   <= 1'b0;
            ld_ack_reg <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            o_reg      <= o_next;
            wrap_reg   <= wrap_next;
            ld_ack_reg <= ld_ack_next;
            locked_reg <= locked_next;
        end
    end

    // All outputs come straight from flops.
    assign O      = o_reg;
    assign WRAP   = wrap_reg;
    assign LD_ACK = ld_ack_reg;
    assign LOCKED = locked_reg;

endmodule

// File: tb/tb_const_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_const_seq_gen
//
// Drives four differently parameterised const_seq_gen instances from one
// shared stimulus stream and compares each against an arithmetic reference
// model. Directed scenarios cover the documented examples; a random phase
// follows. One line is printed per directed transaction.
// -----------------------------------------------------------------------------
module tb_const_seq_gen;

    localparam int N = 4;
    // Per-instance parameters: {WIDTH, INIT, STEP, SAT}
    localparam int P_W   [N] = '{3, 3, 5, 1};
    localparam int P_INIT[N] = '{3, 3, 19, 1};
    localparam int P_STEP[N] = '{1, 3, 7, 1};
    localparam int P_SAT [N] = '{0, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ld = 1'b0;
    logic [31:0] d = '0;
    logic        lock = 1'b0;

    logic [2:0]  o0, o1;
    logic [4:0]  o2;
    logic [0:0]  o3;
    logic [N-1:0] wrap_o, ack_o, locked_o;
    logic [31:0] dut_o [N];

    always #5 clk = ~clk;

    const_seq_gen #(.WIDTH(3), .INIT(3), .STEP(1), .SAT(1'b0)) u0 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .LD(ld), .D(d[2:0]),
        .LOCK(lock), .O(o0), .WRAP(wrap_o[0]), .LD_ACK(ack_o[0]), .LOCKED(locked_o[0]));
    const_seq_gen #(.WIDTH(3), .INIT(3), .STEP(3), .SAT(1'b1)) u1 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .LD(ld), .D(d[2:0]),
        .LOCK(lock), .O(o1), .WRAP(wrap_o[1]), .LD_ACK(ack_o[1]), .LOCKED(locked_o[1]));
    const_seq_gen #(.WIDTH(5), .INIT(19), .STEP(7), .SAT(1'b0)) u2 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .LD(ld), .D(d[4:0]),
        .LOCK(lock), .O(o2), .WRAP(wrap_o[2]), .LD_ACK(ack_o[2]), .LOCKED(locked_o[2]));
    const_seq_gen #(.WIDTH(1), .INIT(1), .STEP(1), .SAT(1'b1)) u3 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .LD(ld), .D(d[0:0]),
        .LOCK(lock), .O(o3), .WRAP(wrap_o[3]), .LD_ACK(ack_o[3]), .LOCKED(locked_o[3]));

    assign dut_o[0] = 32'(o0);
    assign dut_o[1] = 32'(o1);
    assign dut_o[2] = 32'(o2);
    assign dut_o[3] = 32'(o3);

    // -------------------------------------------------------------------------
    // Reference model: plain integer arithmetic on the documented rules.
    // -------------------------------------------------------------------------
    longint m_o     [N];
    bit     m_wrap  [N];
    bit     m_ack   [N];
    bit     m_locked[N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            longint modv;
            longint ex;
            modv = longint'(1) << P_W[i];
            if (!rst_n) begin
                m_o[i]      = longint'(P_INIT[i]) % modv;
                m_wrap[i]   = 1'b0;
                m_ack[i]    = 1'b0;
                m_locked[i] = 1'b0;
            end else if (m_locked[i]) begin
                m_wrap[i] = 1'b0;
                m_ack[i]  = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                m_ack[i]  = 1'b0;
                if (ld) begin
                    m_o[i]   = longint'(d) % modv;
                    m_ack[i] = 1'b1;
                end else if (en) begin
                    case (mode)
                        2'd1: begin
                            ex = m_o[i] + P_STEP[i];
                            if (ex >= modv) begin
                                m_wrap[i] = 1'b1;
                                m_o[i] = (P_SAT[i] != 0) ? modv - 1 : ex - modv;
                            end else begin
                                m_o[i] = ex;
                            end
                        end
                        2'd2: begin
                            ex = m_o[i] - P_STEP[i];
                            if (ex < 0) begin
                                m_wrap[i] = 1'b1;
                                m_o[i] = (P_SAT[i] != 0) ? 0 : ex + modv;
                            end else begin
                                m_o[i] = ex;
                            end
                        end
                        2'd3: begin
                            if (P_W[i] > 1)
                                m_o[i] = (m_o[i] * 2) % modv + m_o[i] / (modv / 2);
                        end
                        default: ;
                    endcase
                end
                if (lock) m_locked[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("o[%0d]", i),      longint'(dut_o[i]),   m_o[i]);
            check($sformatf("wrap[%0d]", i),   longint'(wrap_o[i]),  longint'(m_wrap[i]));
            check($sformatf("ld_ack[%0d]", i), longint'(ack_o[i]),   longint'(m_ack[i]));
            check($sformatf("locked[%0d]", i), longint'(locked_o[i]), longint'(m_locked[i]));
        end
    endtask

    // One clock: inputs set at the falling edge, model advanced at the rising
    // edge, DUT sampled 1 time unit later. MODE is then scrambled between
    // edges, which must have no effect.
    task automatic cycle(input bit r, input bit lk, input bit l, input bit e,
                         input logic [1:0] m, input logic [31:0] dv, input bit verbose);
        @(negedge clk);
        rst_n = r; lock = lk; ld = l; en = e; mode = m; d = dv;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (verbose)
            $display("t=%0t rst_n=%0b lock=%0b ld=%0b en=%0b mode=%0d d=%0d | o0=%0d w0=%0b a0=%0b l0=%0b o1=%0d w1=%0b",
                     $time, r, lk, l, e, m, dv, o0, wrap_o[0], ack_o[0], locked_o[0], o1, wrap_o[1]);
        mode = 2'($urandom_range(0, 3));
    endtask

    int exp036 [6] = '{4, 5, 6, 7, 0, 1};

    initial begin
        // Idle after reset: value stays at INIT, no pulses.
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0, 2'd0, 0, 1);
            check("idle_o", longint'(o0), 3);
        end

        // Wrap-around increment through the top of the range.
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            cycle(1, 0, 0, 1, 2'd1, 0, 1);
            check("inc_o", longint'(o0), exp036[k]);
            check("inc_wrap", longint'(wrap_o[0]), (k == 4) ? 1 : 0);
        end

        // Saturating decrement by 3 from 3: reaches 0, then pins with WRAP.
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        cycle(1, 0, 0, 1, 2'd2, 0, 1);
        check("satdec_o1", longint'(o1), 0);
        check("satdec_w1", longint'(wrap_o[1]), 0);
        cycle(1, 0, 0, 1, 2'd2, 0, 1);
        check("satdec_o2", longint'(o1), 0);
        check("satdec_w2", longint'(wrap_o[1]), 1);

        // Load beats step; back-to-back loads each acknowledged.
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        cycle(1, 0, 1, 1, 2'd1, 5, 1);
        check("ld_o", longint'(o0), 5);
        check("ld_ack", longint'(ack_o[0]), 1);
        cycle(1, 0, 1, 0, 2'd0, 2, 1);
        check("ld2_o", longint'(o0), 2);
        check("ld2_ack", longint'(ack_o[0]), 1);
        cycle(1, 0, 0, 0, 2'd0, 0, 1);
        check("ld_ack_end", longint'(ack_o[0]), 0);

        // Rotate left.
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        cycle(1, 0, 0, 1, 2'd3, 0, 1);
        check("rot_o1", longint'(o0), 6);
        cycle(1, 0, 0, 1, 2'd3, 0, 1);
        check("rot_o2", longint'(o0), 5);

        // Lock with a same-edge load, then frozen until reset.
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        cycle(1, 1, 1, 0, 2'd0, 6, 1);
        check("lock_o", longint'(o0), 6);
        check("lock_locked", longint'(locked_o[0]), 1);
        cycle(1, 0, 1, 1, 2'd1, 1, 1);
        cycle(1, 0, 0, 1, 2'd2, 0, 1);
        check("lock_hold", longint'(o0), 6);
        check("lock_noack", longint'(ack_o[0]), 0);
        cycle(0, 1, 1, 1, 2'd1, 7, 1);
        check("unlock_o", longint'(o0), 3);
        check("unlock_locked", longint'(locked_o[0]), 0);

        // Reset discards a pending pulse.
        cycle(1, 0, 0, 0, 2'd0, 0, 1);
        cycle(1, 0, 1, 0, 2'd0, 1, 1);
        cycle(0, 0, 0, 0, 2'd0, 0, 1);
        check("rst_clears_ack", longint'(ack_o[0]), 0);

        // Random phase.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  $urandom, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/const_seq_gen.md
CONST_SEQ_GEN -- requirements
Module: const_seq_gen

Interface
REQ-001 Parameter WIDTH, default 3: bit width of output value O; legal range 1..32.
REQ-002 Parameter INIT, default 3 (3'b011): value O takes at reset; truncated to WIDTH bits.
REQ-003 Parameter STEP, default 1: increment/decrement amount; legal range 1..2^WIDTH-1.
REQ-004 Parameter SAT, default 0: 0 = wrap-around arithmetic, 1 = saturating arithmetic.
REQ-005 Clocking is fixed: one clock; reset is synchronous and active-low.
REQ-006 CLK  input  1  sole clock; all state updates on rising edge.
REQ-007 RST_N  input  1  synchronous active-low reset.
REQ-008 EN  input  1  step enable; MODE is applied only when EN=1.
REQ-009 MODE  input  2  00 hold, 01 add STEP, 10 subtract STEP, 11 rotate left by 1.
REQ-010 LD  input  1  load request; D is captured when accepted.
REQ-011 D  input  WIDTH  load data.
REQ-012 LOCK  input  1  lock request; freezes the value until next reset.
REQ-013 O  output  WIDTH  current registered value.
REQ-014 WRAP  output  1  one-cycle pulse on overflow/underflow or saturation event.
REQ-015 LD_ACK  output  1  one-cycle pulse confirming an accepted load.
REQ-016 LOCKED  output  1  high while the lock is active.

Function
REQ-017 O, WRAP, LD_ACK, LOCKED shall be registered outputs with no combinational path from any input.
REQ-018 Per-edge priority, highest first: reset, locked, LD, EN+MODE, hold.
REQ-019 When LOCKED=1: O shall hold; LD and EN shall be ignored; LD_ACK=0; WRAP=0.
REQ-020 When LOCK=1 and LOCKED=0: LOCKED shall become 1 on the next edge; that edge's LD/EN request shall still be applied.
REQ-021 LD=1 (unlocked): O <= D on the next edge; LD_ACK=1 during the following cycle only; EN shall be ignored that cycle.
REQ-022 Back-to-back LD shall be accepted every cycle, with one LD_ACK pulse per accepted load.
REQ-023 EN=1, MODE=01: O <= (O+STEP) mod 2^WIDTH if SAT=0, or min(O+STEP, 2^WIDTH-1) if SAT=1.
REQ-024 EN=1, MODE=10: O <= (O-STEP) mod 2^WIDTH if SAT=0, or max(O-STEP, 0) if SAT=1.
REQ-025 EN=1, MODE=11: O <= {O[WIDTH-2:0], O[WIDTH-1]}; when WIDTH=1, O shall hold; WRAP shall stay 0.
REQ-026 EN=1, MODE=00, or EN=0: O shall hold.
REQ-027 WRAP shall be 1 for exactly the cycle after any add/subtract step whose exact result falls outside 0..2^WIDTH-1.
REQ-028 REQ-027 applies in both SAT modes, including a step already sitting at the saturation bound; otherwise WRAP=0.
REQ-029 Arithmetic shall be computed WIDTH+1 bits wide; the carry/borrow bit shall drive WRAP.
REQ-030 Inputs are sampled only at the rising edge of CLK; changing MODE between edges shall have no effect.

Reset
REQ-031 RST_N=0 at a rising edge: O <= INIT[WIDTH-1:0]; WRAP <= 0; LD_ACK <= 0; LOCKED <= 0.
REQ-032 Reset shall override LD, EN and LOCK in the same cycle, including while LOCKED=1.
REQ-033 Reset asserted mid-sequence shall discard any pending LD_ACK or WRAP pulse.
REQ-034 Before the first reset edge, output values are undefined; the bench shall not check them.

Verification (WIDTH=3, INIT=3, STEP=1 unless stated)
REQ-035 Reset then idle 3 cycles -> O=3'b011, WRAP=0, LD_ACK=0, LOCKED=0 throughout.
REQ-036 SAT=0, EN=1, MODE=01 for 6 cycles from O=3 -> O=4,5,6,7,0,1; WRAP=1 only in the cycle O=0.
REQ-037 SAT=1, STEP=3, MODE=10 from O=3 -> O=0, then 0; WRAP=0 then 1.
REQ-038 LD=1, D=5 with EN=1, MODE=01 in the same cycle -> O=5 (no increment); LD_ACK=1 for one cycle.
REQ-039 MODE=11 from O=3'b011 -> 3'b110, then 3'b101; WRAP=0.
REQ-040 LOCK=1 with LD=1, D=6 -> O=6, LOCKED=1; later LD and EN ignored, O stays 6; RST_N=0 -> O=3, LOCKED=0.
